// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND sequencer: op codes, pass counts, state and
// operand-select encodings, and the per-op NAND pass schedule.
package nand_seq_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOTA = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_T = 2'd2,
    SRC_U = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    DST_T = 2'd0,
    DST_U = 2'd1,
    DST_R = 2'd2
  } dst_e;

  typedef struct packed {
    src_e x0;
    src_e x1;
    dst_e dst;
  } pass_t;

  // Number of edges spent in EXEC; the reserved op spends one edge but no pass.
  function automatic logic [2:0] op_passes(input logic [2:0] op);
    case (op)
      OP_NAND: op_passes = 3'd1;
      OP_NOTA: op_passes = 3'd1;
      OP_AND:  op_passes = 3'd2;
      OP_OR:   op_passes = 3'd3;
      OP_NOR:  op_passes = 3'd4;
      OP_XOR:  op_passes = 3'd4;
      OP_XNOR: op_passes = 3'd5;
      default: op_passes = 3'd1;
    endcase
  endfunction

  function automatic pass_t mk_pass(input src_e x0, input src_e x1, input dst_e dst);
    pass_t p;
    p.x0  = x0;
    p.x1  = x1;
    p.dst = dst;
    return p;
  endfunction

  // XOR/XNOR step 2 reads T and writes T; the mux sees the old value this cycle.
  function automatic pass_t op_pass(input logic [2:0] op, input logic [2:0] step);
    pass_t p;
    p = mk_pass(SRC_A, SRC_B, DST_R);
    case (op)
      OP_NOTA: p = mk_pass(SRC_A, SRC_A, DST_R);
      OP_AND: begin
        case (step)
          3'd0:    p = mk_pass(SRC_A, SRC_B, DST_T);
          default: p = mk_pass(SRC_T, SRC_T, DST_R);
        endcase
      end
      OP_OR, OP_NOR: begin
        case (step)
          3'd0:    p = mk_pass(SRC_A, SRC_A, DST_T);
          3'd1:    p = mk_pass(SRC_B, SRC_B, DST_U);
          3'd2:    p = mk_pass(SRC_T, SRC_U, (op == OP_OR) ? DST_R : DST_T);
          default: p = mk_pass(SRC_T, SRC_T, DST_R);
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0:    p = mk_pass(SRC_A, SRC_B, DST_T);
          3'd1:    p = mk_pass(SRC_A, SRC_T, DST_U);
          3'd2:    p = mk_pass(SRC_B, SRC_T, DST_T);
          3'd3:    p = mk_pass(SRC_U, SRC_T, (op == OP_XOR) ? DST_R : DST_T);
          default: p = mk_pass(SRC_T, SRC_T, DST_R);
        endcase
      end
      default: p = mk_pass(SRC_A, SRC_B, DST_R);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/nand_cell.sv
// Shared bitwise NAND resource: y = ~(x0 & x1), purely combinational.
module nand_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y
);

  assign y = ~(x0 & x1);

endmodule

// File: rtl/nand_seq_ctrl.sv
// Sequencer building NOT/AND/OR/NOR/XOR/XNOR from one shared NAND cell, one pass
// per clock. Optional pass counter output enabled by defining NAND_SEQ_STATS_EN.
module nand_seq_ctrl
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef NAND_SEQ_STATS_EN
  ,
  output logic [15:0]      pass_cnt
`endif
);

  // Handshake: start is sampled only while idle (busy=0); an accepted start raises
  // busy from that edge, done pulses for one cycle with result/err valid, and a
  // new start may be accepted in that done cycle. start while busy is dropped.

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] t_q, t_d, u_q, u_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  pass_t            sel;
  logic             last_pass;
  logic [WIDTH-1:0] nand_x0, nand_x1, nand_y;

  nand_cell #(.WIDTH(WIDTH)) u_nand_cell (
    .x0 (nand_x0),
    .x1 (nand_x1),
    .y  (nand_y)
  );

  always_comb begin
    sel       = op_pass(op_q, step_q);
    last_pass = (step_q == (op_passes(op_q) - 3'd1));

    nand_x0 = a_q;
    case (sel.x0)
      SRC_A: nand_x0 = a_q;
      SRC_B: nand_x0 = b_q;
      SRC_T: nand_x0 = t_q;
      SRC_U: nand_x0 = u_q;
      default: nand_x0 = a_q;
    endcase

    nand_x1 = b_q;
    case (sel.x1)
      SRC_A: nand_x1 = a_q;
      SRC_B: nand_x1 = b_q;
      SRC_T: nand_x1 = t_q;
      SRC_U: nand_x1 = u_q;
      default: nand_x1 = b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    t_d      = t_q;
    u_d      = u_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          step_d  = 3'd0;
          err_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_RSVD) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (last_pass) begin
          result_d = nand_y;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          step_d = step_q + 3'd1;
          case (sel.dst)
            DST_T:   t_d = nand_y;
            DST_U:   u_d = nand_y;
            default: t_d = t_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      step_q   <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      u_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      t_q      <= t_d;
      u_q      <= u_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == EXEC);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

`ifdef NAND_SEQ_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic        pass_inc;

  always_comb begin
    pass_inc   = (state_q == EXEC) && (op_q != OP_RSVD);
    pass_cnt_d = pass_cnt_q;
    if (pass_inc && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_d = pass_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= 16'd0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
`endif

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Self-checking bench for nand_seq_ctrl: directed vector table, multi-cycle corner
// sequences and randomized ops against a boolean reference model.
module tb_nand_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, err;
  logic [W-1:0] result;
`ifdef NAND_SEQ_STATS_EN
  logic [15:0]  pass_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_result = '0;
  int           exp_pass = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_err;
    int           exp_n;
  } vec_t;

  vec_t vecs[9];

  nand_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
`ifdef NAND_SEQ_STATS_EN
    ,
    .pass_cnt (pass_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_result(input logic [2:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    case (o)
      3'd0: return ~(x & y);
      3'd1: return ~x;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return ~(x | y);
      3'd5: return x ^ y;
      3'd6: return ~(x ^ y);
      default: return '0;
    endcase
  endfunction

  function automatic int model_passes(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return 1;
      3'd2:       return 2;
      3'd3:       return 3;
      3'd4, 3'd5: return 4;
      3'd6:       return 5;
      default:    return 0;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] o);
    return (o == 3'd7) ? 1 : model_passes(o);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_r, input logic exp_e, input int exp_n,
                        input string tag);
    int lat;
    logic [W-1:0] r;
    exp_q.push_back(exp_r);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_at_accept"}, 32'(busy), 32'd1);
    chk({tag, " err_cleared"}, 32'(err), 32'd0);
    chk({tag, " result_held"}, 32'(result), 32'(held_result));
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = exp_q.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(exp_n));
    chk({tag, " result"}, 32'(result), 32'(r));
    chk({tag, " err"}, 32'(err), 32'(exp_e));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    held_result = r;
    exp_pass += model_passes(o);
  endtask

  initial begin
    int dcount;
    int lat;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{3'd3, 4'b0101, 4'b0011, 4'b0111, 1'b0, 3};
    vecs[1] = '{3'd5, 4'b1100, 4'b1010, 4'b0110, 1'b0, 4};
    vecs[2] = '{3'd7, 4'b1010, 4'b0101, 4'b0000, 1'b1, 1};
    vecs[3] = '{3'd3, 4'b1100, 4'b1010, 4'b1110, 1'b0, 3};
    vecs[4] = '{3'd6, 4'b1100, 4'b1010, 4'b1001, 1'b0, 5};
    vecs[5] = '{3'd0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1};
    vecs[6] = '{3'd1, 4'b0110, 4'b0000, 4'b1001, 1'b0, 1};
    vecs[7] = '{3'd4, 4'b0101, 4'b0011, 4'b1000, 1'b0, 4};
    vecs[8] = '{3'd2, 4'b1111, 4'b0101, 4'b0101, 1'b0, 2};

    // Reset values
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst err", 32'(err), 32'd0);
`ifdef NAND_SEQ_STATS_EN
    chk("rst pass_cnt", 32'(pass_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nonzero result, then asynchronous reset in the middle of an OR
    run_op(3'd0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1, "pre_rst_nand");
    start = 1'b1; op = 3'd3; a = 4'b0101; b = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    #2 rst_n = 1'b1;
    dcount = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    chk("midrst no_done", 32'(dcount), 32'd0);
    held_result = '0;
    exp_pass = 0;

    // Directed table, issued back-to-back in each done cycle
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_err, vecs[i].exp_n,
             $sformatf("vec%0d", i));
`ifdef NAND_SEQ_STATS_EN
      if (i == 2) chk("pass_cnt or_xor_rsvd", 32'(pass_cnt), 32'd7);
`endif
    end

    // start held high through an AND while operands wiggle
    @(posedge clk); #1;
    chk("done single_pulse", 32'(done), 32'd0);
    start = 1'b1; op = 3'd2; a = 4'b1111; b = 4'b0101;
    @(posedge clk); #1;
    chk("hold busy", 32'(busy), 32'd1);
    lat = 0;
    dcount = 0;
    while (done !== 1'b1 && lat < 40) begin
      a  = 4'($urandom);
      b  = 4'($urandom);
      op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (done === 1'b1) dcount++;
    chk("hold latency", 32'(lat), 32'd2);
    chk("hold result", 32'(result), 32'b0101);
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    chk("hold one_done", 32'(dcount), 32'd1);
    chk("hold idle", 32'(busy), 32'd0);
    held_result = 4'b0101;
    exp_pass += 2;

    // Randomized ops against the boolean model, with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ro, ra, rb, model_result(ro, ra, rb), (ro == 3'd7), model_latency(ro),
             $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

`ifdef NAND_SEQ_STATS_EN
    chk("pass_cnt final", 32'(pass_cnt), 32'(exp_pass));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
